// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: opcode and memory status in, datapath strobes and selects out.
// The control unit is the master; the datapath (or bench) is the slave.
interface multicycle_control_unit_if;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       ir_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       mem_2_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
             mem_2_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
             mem_2_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: Moore strobes per state, FETCH ir/pc writes gated by mem_ready.
// 2-4 cycles per instruction after fetch; memory states stall on mem_ready and time out to TRAP.
module multicycle_control_unit #(
   parameter int MAX_WAIT        = 15,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   multicycle_control_unit_if.master         bus,
   output logic [3:0]                        state,
   output logic                              illegal_op,
   output logic                              mem_timeout
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_e     state_q;
   state_e     state_next;
   state_e     state_cur;
   logic [7:0] wait_cnt;
   logic       is_wait_state;
   logic       wait_expired;
   logic       timeout_hit;
   logic       illegal_hit;

   // Reset overrides the visible state so outputs show FETCH decoding while rst is held.
   assign state_cur    = rst ? S_FETCH : state_q;
   assign state        = state_cur;
   assign wait_expired = !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH;
         wait_cnt    <= 8'd0;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_next;
         if (state_next != state_q)
            wait_cnt <= 8'd0;
         else if (is_wait_state && !bus.mem_ready && wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout_hit)
            mem_timeout <= 1'b1;
         if (illegal_hit)
            illegal_op <= 1'b1;
      end
   end

   always_comb begin
      state_next        = state_q;
      is_wait_state     = 1'b0;
      timeout_hit       = 1'b0;
      illegal_hit       = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.ir_write      = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_2_reg     = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;

      case (state_q)
         S_FETCH, S_MEM_RD, S_MEM_WR: begin
            is_wait_state = 1'b1;
            if (bus.mem_ready) begin
               case (state_q)
                  S_FETCH:  state_next = S_DECODE;
                  S_MEM_RD: state_next = S_MEM_WB;
                  default:  state_next = S_FETCH;
               endcase
            end else if (wait_expired) begin
               state_next  = S_TRAP;
               timeout_hit = 1'b1;
            end
         end
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
               OP_R:              state_next = S_EXEC_R;
               OP_I:              state_next = S_EXEC_I;
               OP_BEQ:            state_next = S_BRANCH;
               OP_JAL:            state_next = S_JUMP;
               default: begin
                  if (TRAP_ON_ILLEGAL) begin
                     state_next  = S_TRAP;
                     illegal_hit = 1'b1;
                  end else begin
                     state_next  = S_FETCH;
                  end
               end
            endcase
         end
         S_MEM_ADDR: state_next = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
         default: state_next = S_TRAP;
      endcase

      case (state_cur)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE:   bus.alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
         end
         S_MEM_WB: begin
            bus.reg_write = 1'b1;
            bus.mem_2_reg = 1'b1;
         end
         S_MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
         end
         S_EXEC_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_ALU_WB:   bus.reg_write = 1'b1;
         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
         end
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench: two control units (trap / no-trap on illegal opcodes,
// different wait limits) checked each cycle against an instruction-path reference model.
module tb_multicycle_control_unit;
   localparam int NCYC = 6000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   logic [3:0] st0, st1;
   logic ill0, ill1, to0, to1;

   multicycle_control_unit_if bus0();
   multicycle_control_unit_if bus1();

   multicycle_control_unit #(.MAX_WAIT(15), .TRAP_ON_ILLEGAL(1'b1)) dut0 (
      .clk(clk), .rst(rst0), .bus(bus0), .state(st0), .illegal_op(ill0), .mem_timeout(to0)
   );
   multicycle_control_unit #(.MAX_WAIT(2), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1), .state(st1), .illegal_op(ill1), .mem_timeout(to1)
   );

   logic [20:0] obs0, obs1;
   assign obs0 = {st0, ill0, to0, bus0.pc_write, bus0.pc_write_cond, bus0.ir_write, bus0.iord,
                  bus0.mem_read, bus0.mem_write, bus0.mem_2_reg, bus0.reg_write,
                  bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.pc_source};
   assign obs1 = {st1, ill1, to1, bus1.pc_write, bus1.pc_write_cond, bus1.ir_write, bus1.iord,
                  bus1.mem_read, bus1.mem_write, bus1.mem_2_reg, bus1.reg_write,
                  bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.pc_source};

   int checks = 0;
   int errors = 0;
   logic [20:0] exp_q0[$];
   logic [20:0] exp_q1[$];

   // Reference model: per unit, the list of states an instruction walks after FETCH.
   int         maxw[2];
   bit         trap_ill[2];
   int         m_state[2];
   int         m_wait[2];
   int         m_path[2][4];
   int         m_len[2];
   int         m_idx[2];
   int         m_stuck[2];
   int         m_trapcyc[2];
   bit         m_ill[2];
   bit         m_to[2];
   logic [6:0] cur_op[2];

   function automatic logic [14:0] exp_ctrl(input int s, input bit rdy);
      logic pcw, pcwc, irw, iord, mr, mw, m2r, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, irw, iord, mr, mw, m2r, rw, asa} = 9'b0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (s)
         0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1:  asb = 2'b11;
         2:  begin asa = 1'b1; asb = 2'b10; end
         3:  begin mr = 1'b1; iord = 1'b1; end
         4:  begin rw = 1'b1; m2r = 1'b1; end
         5:  begin mw = 1'b1; iord = 1'b1; end
         6:  begin asa = 1'b1; aop = 2'b10; end
         7:  begin asa = 1'b1; asb = 2'b10; end
         8:  rw = 1'b1;
         9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
         10: begin pcw = 1'b1; psrc = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, irw, iord, mr, mw, m2r, rw, asa, asb, aop, psrc};
   endfunction

   task automatic build_path(input int k, input logic [6:0] op);
      case (op)
         7'b0000011: begin m_path[k][0] = 1; m_path[k][1] = 2; m_path[k][2] = 3; m_path[k][3] = 4; m_len[k] = 4; end
         7'b0100011: begin m_path[k][0] = 1; m_path[k][1] = 2; m_path[k][2] = 5; m_len[k] = 3; end
         7'b0110011: begin m_path[k][0] = 1; m_path[k][1] = 6; m_path[k][2] = 8; m_len[k] = 3; end
         7'b0010011: begin m_path[k][0] = 1; m_path[k][1] = 7; m_path[k][2] = 8; m_len[k] = 3; end
         7'b1100011: begin m_path[k][0] = 1; m_path[k][1] = 9; m_len[k] = 2; end
         7'b1101111: begin m_path[k][0] = 1; m_path[k][1] = 10; m_len[k] = 2; end
         default: begin m_path[k][0] = 1; m_path[k][1] = 11; m_len[k] = trap_ill[k] ? 2 : 1; end
      endcase
   endtask

   // Produce this cycle's expected outputs, then advance the model across the clock edge.
   task automatic model_cycle(input int k, input bit r, input bit rdy, input logic [6:0] op,
                              output logic [20:0] exp);
      int s;
      s = r ? 0 : m_state[k];
      exp = {4'(s), m_ill[k], m_to[k], exp_ctrl(s, rdy)};
      if (r) begin
         m_state[k] = 0; m_wait[k] = 0; m_ill[k] = 1'b0; m_to[k] = 1'b0;
         return;
      end
      if (m_state[k] == 11) return;
      if ((m_state[k] inside {0, 3, 5}) && !rdy) begin
         if (m_wait[k] == maxw[k]) begin
            m_state[k] = 11; m_to[k] = 1'b1; m_wait[k] = 0;
         end else if (m_wait[k] < 255) begin
            m_wait[k]++;
         end
         return;
      end
      if (m_state[k] == 0) begin
         build_path(k, op);
         m_idx[k] = 0;
      end else begin
         m_idx[k]++;
      end
      m_state[k] = (m_idx[k] < m_len[k]) ? m_path[k][m_idx[k]] : 0;
      if (m_state[k] == 11) m_ill[k] = 1'b1;
      m_wait[k] = 0;
   endtask

   task automatic pick(input int k, input bit force_rst, output bit r, output bit rdy,
                       output logic [6:0] op);
      int sel;
      r = force_rst || (m_state[k] == 11 && m_trapcyc[k] >= 3) || ($urandom_range(0, 99) == 0);
      if (m_state[k] == 11) m_trapcyc[k]++; else m_trapcyc[k] = 0;
      if (m_state[k] == 0 && m_wait[k] == 0) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: cur_op[k] = 7'b0110011;
            1: cur_op[k] = 7'b0010011;
            2: cur_op[k] = 7'b1100011;
            3: cur_op[k] = 7'b1101111;
            4, 5: cur_op[k] = 7'b0000011;
            6: cur_op[k] = 7'b0100011;
            7: cur_op[k] = 7'b1111111;
            default: cur_op[k] = 7'($urandom_range(0, 127));
         endcase
         sel = $urandom_range(0, 11);
         m_stuck[k] = (sel == 0) ? 1 : (sel <= 2) ? 2 : 0;
      end
      op = cur_op[k];
      if (m_stuck[k] == 1 && (m_state[k] inside {0, 3, 5}))
         rdy = 1'b0;
      else if (m_stuck[k] == 2 && (m_state[k] inside {3, 5}))
         rdy = 1'b0;
      else
         rdy = ($urandom_range(0, 2) != 0);
   endtask

   initial begin : stimulus
      bit r, rdy;
      logic [6:0] op;
      logic [20:0] e;
      maxw[0] = 15; trap_ill[0] = 1'b1;
      maxw[1] = 2;  trap_ill[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0; m_wait[k] = 0; m_len[k] = 0; m_idx[k] = 0;
         m_stuck[k] = 0; m_trapcyc[k] = 0; m_ill[k] = 1'b0; m_to[k] = 1'b0;
         cur_op[k] = 7'b0110011;
      end
      rst0 = 1'b1; rst1 = 1'b1;
      bus0.mem_ready = 1'b0; bus0.opcode = 7'd0;
      bus1.mem_ready = 1'b0; bus1.opcode = 7'd0;
      @(posedge clk); #1;
      for (int c = 0; c < NCYC; c++) begin
         pick(0, c == 0, r, rdy, op);
         rst0 = r; bus0.mem_ready = rdy; bus0.opcode = op;
         model_cycle(0, r, rdy, op, e);
         exp_q0.push_back(e);
         pick(1, c == 0, r, rdy, op);
         rst1 = r; bus1.mem_ready = rdy; bus1.opcode = op;
         model_cycle(1, r, rdy, op, e);
         exp_q1.push_back(e);
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : monitor
      logic [20:0] e;
      forever begin
         @(negedge clk);
         if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            checks++;
            if (obs0 !== e) begin
               errors++;
               $display("FAIL unit0_outputs t=%0t got=%h exp=%h (state,ill,to,strobes)", $time, obs0, e);
            end
         end
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checks++;
            if (obs1 !== e) begin
               errors++;
               $display("FAIL unit1_outputs t=%0t got=%h exp=%h (state,ill,to,strobes)", $time, obs1, e);
            end
         end
      end
   end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15: max cycles a memory state waits for mem_ready before timeout; legal range 1..255.
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1: 1 = unknown opcode enters TRAP; 0 = unknown opcode treated as NOP, returns to FETCH.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high. Ports: clk (input, 1, rising-edge clock); rst (input, 1, synchronous active-high reset).
REQ-004 opcode  input  7  instruction opcode from IR, valid from DECODE onward.
REQ-005 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, mem_2_reg, reg_write  output  1 each  datapath strobes/selects.
REQ-007 alu_src_a  output  1  0 = PC, 1 = rs1.
REQ-008 alu_src_b  output  2  00 = rs2, 01 = constant 4, 10 = imm, 11 = imm (branch offset).
REQ-009 alu_op  output  2  00 = ADD, 01 = SUB, 10 = R-type decode.
REQ-010 pc_source  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
REQ-011 state  output  4  current FSM state code, for debug.
REQ-012 illegal_op, mem_timeout  output  1 each  sticky error flags.

Function
REQ-013 Opcodes SHALL decode as: R 0110011, I 0010011, BEQ 1100011, JAL 1101111, LOAD 0000011, STORE 0100011.
REQ-014 States and codes SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JUMP 10, TRAP 11.
REQ-015 All outputs SHALL be Moore functions of state, except ir_write/pc_write in FETCH, which are also gated by mem_ready; unlisted outputs are 0.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; go to DECODE on mem_ready, else hold.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next: LOAD/STORE->MEM_ADDR, R->EXEC_R, I->EXEC_I, BEQ->BRANCH, JAL->JUMP, other->TRAP (TRAP_ON_ILLEGAL=1) or FETCH (=0).
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; LOAD->MEM_RD, STORE->MEM_WR.
REQ-019 MEM_RD: mem_read=1, iord=1; MEM_WB on mem_ready, else hold.
REQ-020 MEM_WB: reg_write=1, mem_2_reg=1; ->FETCH.
REQ-021 MEM_WR: mem_write=1, iord=1; FETCH on mem_ready, else hold.
REQ-022 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; ->ALU_WB. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; ->ALU_WB.
REQ-023 ALU_WB: reg_write=1, mem_2_reg=0; ->FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH.
REQ-025 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-026 Wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR, increment each cycle those states hold without mem_ready, and saturate.
REQ-027 In FETCH/MEM_RD/MEM_WR, if mem_ready is low and the counter equals MAX_WAIT, next state SHALL be TRAP and mem_timeout SHALL set; mem_ready high on that same cycle wins (normal transition, no timeout).
REQ-028 Illegal opcode in DECODE with TRAP_ON_ILLEGAL=1 SHALL set illegal_op when entering TRAP.
REQ-029 TRAP: all strobes 0, FSM holds until rst; illegal_op and mem_timeout are sticky and cleared only by rst.
REQ-030 Instruction latencies from FETCH completion: R/I 3 cycles, LOAD 4, STORE 3+wait, BEQ/JAL 2.

Reset
REQ-031 rst high at a clock edge SHALL force state=FETCH, wait counter=0, illegal_op=0, mem_timeout=0, regardless of current state (including mid-memory-wait and TRAP).
REQ-032 During reset cycles outputs SHALL equal FETCH decoding with mem_ready-gated strobes.

Verification
REQ-033 R-type 0110011, mem_ready=1 in FETCH -> states 0,1,6,8,0; reg_write=1 only in ALU_WB; alu_op=10 in EXEC_R.
REQ-034 LOAD, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with reg_write=1, mem_2_reg=1.
REQ-035 STORE, mem_ready never asserted, MAX_WAIT=15 -> TRAP after 16 cycles in MEM_WR, mem_timeout=1, mem_write=0 in TRAP.
REQ-036 Opcode 1111111: TRAP_ON_ILLEGAL=1 -> TRAP, illegal_op=1; TRAP_ON_ILLEGAL=0 -> DECODE then FETCH, illegal_op=0.
REQ-037 BEQ -> BRANCH with pc_write_cond=1, pc_source=01, alu_op=01; rst asserted in MEM_RD or TRAP -> next cycle state=0, flags=0.
